frame_decoder: RTL and testbench
================================

// Module: frame_decoder
// PURPOSE
//  Parametrised successor to the UART character decoder. Converts a raw UART byte stream
//  into framed tokens (START / DATA / END / ABORT) with escape handling, frame-length
//  policing and an output FIFO. Sits between UARTReceiver and ProtocolInterface.
//  Adds programmable control characters, a valid/ready output and error counting.
// PARAMETERS
//  DATA_W      8      byte width
//  START_CHAR  8'h01  start-of-frame character
//  END_CHAR    8'h17  end-of-frame character
//  ESC_CHAR    8'h1B  escape character; the next byte is taken literally
//  MAX_LEN     16     max payload bytes per frame (1..255)
//  FIFO_DEPTH  4      output FIFO entries (power of 2, >=2)
//  EDGE_IN     1      1: rising edge of in_drdy marks a byte; 0: in_drdy is a 1-cycle strobe
// PORTS
//  clk         in   1       module clock
//  reset_n     in   1       asynchronous reset, active low
//  in_drdy     in   1       byte-ready from UARTReceiver
//  in_data     in   DATA_W  received byte
//  out_valid   out  1       FIFO head holds a token
//  out_ready   in   1       consumer accepts the head when out_valid&out_ready
//  out_kind    out  2       00 DATA, 01 START, 10 END, 11 ABORT
//  out_data    out  DATA_W  payload byte; 0 for non-DATA tokens
//  in_frame    out  1       high between an accepted START and its END/ABORT
//  frame_len   out  8       payload bytes accepted in the current frame
//  err_pulse   out  1       1-cycle pulse on any error event
//  err_count   out  8       error events, saturates at 255
// BEHAVIOUR
//  Reset (async, reset_n=0): FSM=IDLE; FIFO empty; every output 0; edge detector primed
//   so that in_drdy already high at release does not count as a byte.
//  Byte event: EDGE_IN=1 -> in_drdy 0->1 between consecutive clk edges; EDGE_IN=0 -> in_drdy=1.
//   in_data is sampled in the same cycle as the event.
//  FSM states: IDLE, FRAME, ESC.
//   IDLE : START -> push START, frame_len=0, go FRAME. Any other byte (incl. ESC, END) ->
//          discard and raise an error.
//   FRAME: START -> push ABORT then START (2 entries), frame_len=0, error, stay FRAME.
//          END -> push END, go IDLE. ESC -> go ESC, nothing pushed.
//          other -> push DATA if frame_len<MAX_LEN, frame_len++.
//          If frame_len==MAX_LEN -> push ABORT, error, go IDLE.
//   ESC  : any byte (incl. START/END/ESC) -> treated as DATA per the FRAME rule, go FRAME.
//  Push latency: token is visible at out_valid 1 clk after the byte event (registered FIFO).
//  FIFO: push and pop in the same cycle are both legal at any occupancy.
//   A push when full (and no pop) drops the whole token, raises an error and leaves the FSM
//   transition unaffected. For a START-in-FRAME needing 2 entries with only 1 free,
//   ABORT is written, START is dropped and an error is raised.
//  out_kind/out_data are stable while out_valid=1 and out_ready=0.
//  Errors: err_pulse=1 for exactly one cycle per byte event with >=1 error.
//   err_count increments by 1 per such event and holds at 255.
//  in_frame is high in FRAME and ESC.
//  frame_len is 8 bits, held after END/ABORT until the next START.
//  Back-to-back byte events on consecutive cycles (EDGE_IN=0) are all processed.
// TESTING
//  1. Bytes 01 41 42 17, out_ready=1 -> tokens START, DATA 41, DATA 42, END;
//     frame_len=2; err_count=0.
//  2. Bytes 01 1B 17 1B 1B 17 -> START, DATA 17, DATA 1B, END; no errors.
//  3. MAX_LEN=2, bytes 01 AA BB CC -> START, DATA AA, DATA BB, ABORT; err_count=1;
//     in_frame=0 after CC.
//  4. Bytes 55 01 33 01 44 17 -> 55 is dropped (error); then START, DATA 33, ABORT, START,
//     DATA 44, END; err_count=2.
//  5. out_ready=0, FIFO_DEPTH=4, bytes 01 10 20 30 40 -> FIFO full after 30, 40 dropped;
//     err_pulse once, err_count=1; then out_ready=1 drains START, 10, 20, 30.
//  6. Reset_n pulsed low mid-frame with FIFO holding 3 tokens -> out_valid=0,
//     in_frame=0 and err_count=0 immediately; in_drdy held high at release gives no token.

Source files
------------

// File: rtl/frame_decoder.sv
// UART byte stream to framed token decoder: START/DATA/END/ABORT tokens with escape
// handling, frame-length policing, an output FIFO and saturating error counting.
//
// state | meaning
// IDLE  | waiting for START, other bytes are errors
// FRAME | inside a frame, collecting payload
// ESC   | previous byte was ESC, next byte is literal payload
module frame_decoder #(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] START_CHAR = 8'h01,
  parameter logic [DATA_W-1:0] END_CHAR   = 8'h17,
  parameter logic [DATA_W-1:0] ESC_CHAR   = 8'h1B,
  parameter int                MAX_LEN    = 16,
  parameter int                FIFO_DEPTH = 4,
  parameter bit                EDGE_IN    = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_drdy,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic [DATA_W-1:0] out_data,
  output logic              in_frame,
  output logic [7:0]        frame_len,
  output logic              err_pulse,
  output logic [7:0]        err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = DATA_W + 2;
  localparam logic [1:0] K_DATA  = 2'b00;
  localparam logic [1:0] K_START = 2'b01;
  localparam logic [1:0] K_END   = 2'b10;
  localparam logic [1:0] K_ABORT = 2'b11;

  typedef enum logic [1:0] {IDLE, FRAME, ESC} state_t;

  state_t          state, state_n;
  logic [7:0]      len_n;
  logic            drdy_q;
  logic            byte_ev;
  logic            take_data;
  logic [1:0]      n_req;
  logic [1:0]      n_wr;
  logic [TW-1:0]   tok0, tok1;
  logic            fsm_err, fifo_err, err_ev;
  logic            pop;
  logic [AW:0]     cnt;
  logic [AW:0]     free;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [TW-1:0]   mem [FIFO_DEPTH];

  assign byte_ev = EDGE_IN ? (in_drdy & ~drdy_q) : in_drdy;

  always_comb begin
    state_n   = state;
    len_n     = frame_len;
    n_req     = 2'd0;
    tok0      = '0;
    tok1      = '0;
    fsm_err   = 1'b0;
    take_data = 1'b0;
    if (byte_ev) begin
      case (state)
        IDLE: begin
          if (in_data == START_CHAR) begin
            n_req   = 2'd1;
            tok0    = {K_START, {DATA_W{1'b0}}};
            len_n   = 8'd0;
            state_n = FRAME;
          end else begin
            fsm_err = 1'b1;
          end
        end
        FRAME: begin
          if (in_data == START_CHAR) begin
            n_req   = 2'd2;
            tok0    = {K_ABORT, {DATA_W{1'b0}}};
            tok1    = {K_START, {DATA_W{1'b0}}};
            len_n   = 8'd0;
            fsm_err = 1'b1;
          end else if (in_data == END_CHAR) begin
            n_req   = 2'd1;
            tok0    = {K_END, {DATA_W{1'b0}}};
            state_n = IDLE;
          end else if (in_data == ESC_CHAR) begin
            state_n = ESC;
          end else begin
            take_data = 1'b1;
          end
        end
        ESC:     take_data = 1'b1;
        default: state_n = IDLE;
      endcase
      if (take_data) begin
        n_req = 2'd1;
        if (frame_len < 8'(MAX_LEN)) begin
          tok0    = {K_DATA, in_data};
          len_n   = frame_len + 8'd1;
          state_n = FRAME;
        end else begin
          tok0    = {K_ABORT, {DATA_W{1'b0}}};
          fsm_err = 1'b1;
          state_n = IDLE;
        end
      end
    end
  end

  // A pop in the same cycle frees the head slot for this cycle's push.
  assign pop  = out_valid & out_ready;
  assign free = (AW+1)'(FIFO_DEPTH) - cnt + (AW+1)'(pop);

  always_comb begin
    n_wr     = 2'd0;
    fifo_err = 1'b0;
    if (n_req == 2'd1) begin
      if (free != '0) n_wr = 2'd1;
      else            fifo_err = 1'b1;
    end else if (n_req == 2'd2) begin
      if (free >= (AW+1)'(2)) begin
        n_wr = 2'd2;
      end else begin
        n_wr     = (free != '0) ? 2'd1 : 2'd0;
        fifo_err = 1'b1;
      end
    end
  end

  assign err_ev = fsm_err | fifo_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      frame_len <= 8'd0;
      drdy_q    <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      err_pulse <= 1'b0;
      err_count <= 8'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state     <= state_n;
      frame_len <= len_n;
      drdy_q    <= in_drdy;
      if (n_wr != 2'd0) mem[wr_ptr] <= tok0;
      if (n_wr == 2'd2) mem[wr_ptr + AW'(1)] <= tok1;
      wr_ptr    <= wr_ptr + AW'(n_wr);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt       <= cnt + (AW+1)'(n_wr) - (AW+1)'(pop);
      err_pulse <= err_ev;
      if (err_ev && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  assign out_valid            = (cnt != '0);
  assign {out_kind, out_data} = mem[rd_ptr];
  assign in_frame             = (state != IDLE);

endmodule

// File: tb/tb_frame_decoder.sv
// Directed bench for frame_decoder: table-driven byte vectors plus corner sequences
// for length abort, FIFO overflow and mid-frame reset.
module tb_frame_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, in_drdy, in_drdy2, out_ready;
  logic [7:0] in_data;
  logic       out_valid, in_frame, err_pulse;
  logic [1:0] out_kind;
  logic [7:0] out_data, frame_len, err_count;
  logic       out_valid_2, in_frame_2, err_pulse_2;
  logic [1:0] out_kind_2;
  logic [7:0] out_data_2, frame_len_2, err_count_2;

  frame_decoder dut (
    .clk(clk), .reset_n(reset_n), .in_drdy(in_drdy), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind), .out_data(out_data),
    .in_frame(in_frame), .frame_len(frame_len), .err_pulse(err_pulse), .err_count(err_count)
  );

  frame_decoder #(.MAX_LEN(2), .EDGE_IN(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_drdy(in_drdy2), .in_data(in_data),
    .out_valid(out_valid_2), .out_ready(out_ready), .out_kind(out_kind_2), .out_data(out_data_2),
    .in_frame(in_frame_2), .frame_len(frame_len_2), .err_pulse(err_pulse_2), .err_count(err_count_2)
  );

  typedef struct {
    logic [7:0] b;
    logic       exp_frame;
    logic [7:0] exp_len;
    logic [7:0] exp_errs;
    logic       exp_pulse;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] q1[$];
  logic [9:0] q2[$];

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready)     q1.push_back({out_kind, out_data});
    if (reset_n && out_valid_2 && out_ready)   q2.push_back({out_kind_2, out_data_2});
  end

  function automatic vec_t mk(logic [7:0] b, logic f, logic [7:0] l, logic [7:0] e, logic p);
    vec_t v;
    v.b = b; v.exp_frame = f; v.exp_len = l; v.exp_errs = e; v.exp_pulse = p;
    return v;
  endfunction

  function automatic logic [9:0] tok(logic [1:0] k, logic [7:0] d);
    return {k, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    in_data = b;
    in_drdy = 1'b1;
    @(posedge clk); #1;
    in_drdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_table(input string tag, input vec_t tbl[$]);
    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i].b);
      check($sformatf("%s[%0d] in_frame", tag, i),  32'(in_frame),  32'(tbl[i].exp_frame));
      check($sformatf("%s[%0d] frame_len", tag, i), 32'(frame_len), 32'(tbl[i].exp_len));
      check($sformatf("%s[%0d] err_count", tag, i), 32'(err_count), 32'(tbl[i].exp_errs));
      check($sformatf("%s[%0d] err_pulse", tag, i), 32'(err_pulse), 32'(tbl[i].exp_pulse));
    end
  endtask

  task automatic cmp_q(input string tag, input logic [9:0] got[$], input logic [9:0] exp[$]);
    check({tag, " token count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) check($sformatf("%s token %0d", tag, i), 32'(got[i]), 32'(exp[i]));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  vec_t t_main[$];
  vec_t t_full[$];
  vec_t t_rst[$];
  logic [9:0] e_main[$];
  logic [9:0] e_len[$];
  logic [9:0] e_full[$];

  initial begin
    // bytes 01 41 42 17 | 01 1B 17 1B 1B 17 | 55 01 33 01 44 17
    t_main.push_back(mk(8'h01, 1, 0, 0, 0));
    t_main.push_back(mk(8'h41, 1, 1, 0, 0));
    t_main.push_back(mk(8'h42, 1, 2, 0, 0));
    t_main.push_back(mk(8'h17, 0, 2, 0, 0));
    t_main.push_back(mk(8'h01, 1, 0, 0, 0));
    t_main.push_back(mk(8'h1B, 1, 0, 0, 0));
    t_main.push_back(mk(8'h17, 1, 1, 0, 0));
    t_main.push_back(mk(8'h1B, 1, 1, 0, 0));
    t_main.push_back(mk(8'h1B, 1, 2, 0, 0));
    t_main.push_back(mk(8'h17, 0, 2, 0, 0));
    t_main.push_back(mk(8'h55, 0, 2, 1, 1));
    t_main.push_back(mk(8'h01, 1, 0, 1, 0));
    t_main.push_back(mk(8'h33, 1, 1, 1, 0));
    t_main.push_back(mk(8'h01, 1, 0, 2, 1));
    t_main.push_back(mk(8'h44, 1, 1, 2, 0));
    t_main.push_back(mk(8'h17, 0, 1, 2, 0));
    e_main = '{tok(2'b01, 8'h00), tok(2'b00, 8'h41), tok(2'b00, 8'h42), tok(2'b10, 8'h00),
               tok(2'b01, 8'h00), tok(2'b00, 8'h17), tok(2'b00, 8'h1B), tok(2'b10, 8'h00),
               tok(2'b01, 8'h00), tok(2'b00, 8'h33), tok(2'b11, 8'h00), tok(2'b01, 8'h00),
               tok(2'b00, 8'h44), tok(2'b10, 8'h00)};
    e_len  = '{tok(2'b01, 8'h00), tok(2'b00, 8'hAA), tok(2'b00, 8'hBB), tok(2'b11, 8'h00)};
    t_full.push_back(mk(8'h01, 1, 0, 0, 0));
    t_full.push_back(mk(8'h10, 1, 1, 0, 0));
    t_full.push_back(mk(8'h20, 1, 2, 0, 0));
    t_full.push_back(mk(8'h30, 1, 3, 0, 0));
    t_full.push_back(mk(8'h40, 1, 4, 1, 1));
    e_full = '{tok(2'b01, 8'h00), tok(2'b00, 8'h10), tok(2'b00, 8'h20), tok(2'b00, 8'h30)};
    t_rst.push_back(mk(8'h55, 0, 0, 1, 1));
    t_rst.push_back(mk(8'h01, 1, 0, 1, 0));
    t_rst.push_back(mk(8'h10, 1, 1, 1, 0));
    t_rst.push_back(mk(8'h20, 1, 2, 1, 0));

    reset_n = 1'b0; in_drdy = 1'b0; in_drdy2 = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_kind",  32'(out_kind),  0);
    check("reset out_data",  32'(out_data),  0);
    check("reset in_frame",  32'(in_frame),  0);
    check("reset frame_len", 32'(frame_len), 0);
    check("reset err_pulse", 32'(err_pulse), 0);
    check("reset err_count", 32'(err_count), 0);

    run_table("main", t_main);
    repeat (3) @(negedge clk);
    cmp_q("main", q1, e_main);
    q1.delete();

    // Back-to-back strobes into the MAX_LEN=2 strobe-mode instance
    @(posedge clk); #1;
    in_drdy2 = 1'b1; in_data = 8'h01;
    @(posedge clk); #1 in_data = 8'hAA;
    @(posedge clk); #1 in_data = 8'hBB;
    @(posedge clk); #1 in_data = 8'hCC;
    @(posedge clk); #1 in_drdy2 = 1'b0;
    @(negedge clk);
    check("len in_frame",   32'(in_frame_2),  0);
    check("len frame_len",  32'(frame_len_2), 2);
    check("len err_count",  32'(err_count_2), 1);
    check("len err_pulse",  32'(err_pulse_2), 1);
    @(negedge clk);
    check("len err_pulse end", 32'(err_pulse_2), 0);
    repeat (3) @(negedge clk);
    cmp_q("len", q2, e_len);

    // FIFO overflow with consumer stalled
    do_reset();
    out_ready = 1'b0;
    run_table("full", t_full);
    check("full out_valid", 32'(out_valid), 1);
    check("full head kind", 32'(out_kind),  1);
    check("full head data", 32'(out_data),  0);
    check("full token count stalled", 32'(q1.size()), 0);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (10) @(negedge clk);
    cmp_q("full", q1, e_full);
    check("full drained", 32'(out_valid), 0);
    q1.delete();

    // Reset mid-frame with 3 tokens queued and in_drdy held high across release
    do_reset();
    out_ready = 1'b0;
    run_table("rst", t_rst);
    check("rst pre out_valid", 32'(out_valid), 1);
    @(posedge clk); #1 in_drdy = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst out_valid", 32'(out_valid), 0);
    check("rst in_frame",  32'(in_frame),  0);
    check("rst err_count", 32'(err_count), 0);
    check("rst frame_len", 32'(frame_len), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("release out_valid", 32'(out_valid), 0);
    check("release in_frame",  32'(in_frame),  0);
    check("release err_count", 32'(err_count), 0);
    check("release tokens",    32'(q1.size()), 0);
    @(posedge clk); #1 in_drdy = 1'b0;
    send(8'h01);
    check("after release START in_frame", 32'(in_frame), 1);
    @(negedge clk);
    check("after release START token", 32'(q1.size()), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
